// File: rtl/ft232h_tx_arbiter_if.sv
// Channel-side and driver-side signals of the FT232H transmit arbiter.
// The slave modport is the arbiter's view; master is the producer/driver side.
interface ft232h_tx_arbiter_if #(
  parameter int unsigned NUM_CH = 4
);
  logic [8*NUM_CH-1:0] ch_data_in;
  logic [NUM_CH-1:0]   ch_valid_in;
  logic [NUM_CH-1:0]   ch_full_out;
  logic [NUM_CH-1:0]   ch_overflow_out;
  logic [7:0]          fifo_data_out;
  logic                fifo_data_valid_out;
  logic                fifo_ready_in;

  modport master (
    output ch_data_in,
    output ch_valid_in,
    output fifo_ready_in,
    input  ch_full_out,
    input  ch_overflow_out,
    input  fifo_data_out,
    input  fifo_data_valid_out
  );

  modport slave (
    input  ch_data_in,
    input  ch_valid_in,
    input  fifo_ready_in,
    output ch_full_out,
    output ch_overflow_out,
    output fifo_data_out,
    output fifo_data_valid_out
  );
endinterface

// File: rtl/ft232h_tx_arbiter.sv
// Round-robin packetizer sharing one FT232H transmit path among NUM_CH byte producers.
// Each packet is a {channel, length} header byte followed by up to MAX_BURST payload bytes.
module ft232h_tx_arbiter #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_BURST  = 15
) (
  input logic              clk_in,
  input logic              nreset_in,
  ft232h_tx_arbiter_if.slave io_bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;

  logic [7:0]        r_mem   [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]     r_wptr  [NUM_CH];
  logic [AW-1:0]     r_rptr  [NUM_CH];
  logic [CW-1:0]     r_count [NUM_CH];
  logic [CW-1:0]     w_count_d [NUM_CH];
  logic [NUM_CH-1:0] w_push, w_pop, w_full_now;
  logic [NUM_CH-1:0] r_full, r_ovf;

  state_e        r_state, w_state_d;
  logic [GW-1:0] r_gnt, w_gnt_d;
  logic [GW-1:0] r_rr_ptr, w_rr_ptr_d;
  logic [3:0]    r_len, w_len_d;
  logic [3:0]    r_rem, w_rem_d;
  logic          w_found;
  logic [GW-1:0] w_sel;
  logic [3:0]    w_len;
  logic [3:0]    w_gnt4;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_full_now[k] = (r_count[k] == CW'(FIFO_DEPTH));
      // A full FIFO drops the push even if it is popped in the same cycle.
      w_push[k] = io_bus.ch_valid_in[k] & ~w_full_now[k];
      w_pop[k]  = (r_state == StPayload) && io_bus.fifo_ready_in && (r_gnt == GW'(k));
      w_count_d[k] = r_count[k];
      if (w_push[k] && !w_pop[k]) begin
        w_count_d[k] = r_count[k] + 1'b1;
      end else if (w_pop[k] && !w_push[k]) begin
        w_count_d[k] = r_count[k] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_push[k]) begin
        r_mem[k][r_wptr[k]] <= io_bus.ch_data_in[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!nreset_in) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_wptr[k]  <= '0;
        r_rptr[k]  <= '0;
        r_count[k] <= '0;
      end
      r_full <= '0;
      r_ovf  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_push[k]) begin
          r_wptr[k] <= r_wptr[k] + 1'b1;
        end
        if (w_pop[k]) begin
          r_rptr[k] <= r_rptr[k] + 1'b1;
        end
        r_count[k] <= w_count_d[k];
        r_full[k]  <= (w_count_d[k] == CW'(FIFO_DEPTH));
        if (io_bus.ch_valid_in[k] && w_full_now[k]) begin
          r_ovf[k] <= 1'b1;
        end
      end
    end
  end

  // Rotating priority scan starting at the round-robin pointer.
  always_comb begin
    int unsigned   idx;
    logic [GW-1:0] cand;
    idx     = 0;
    cand    = '0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = 32'(r_rr_ptr) + i;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      cand = GW'(idx);
      if (!w_found && (r_count[cand] != '0)) begin
        w_found = 1'b1;
        w_sel   = cand;
      end
    end
    w_len = (r_count[w_sel] > CW'(MAX_BURST)) ? 4'(MAX_BURST) : 4'(r_count[w_sel]);
  end

  always_ff @(posedge clk_in) begin
    if (!nreset_in) begin
      r_state  <= StIdle;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
      r_len    <= '0;
      r_rem    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_gnt    <= w_gnt_d;
      r_rr_ptr <= w_rr_ptr_d;
      r_len    <= w_len_d;
      r_rem    <= w_rem_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_gnt_d    = r_gnt;
    w_rr_ptr_d = r_rr_ptr;
    w_len_d    = r_len;
    w_rem_d    = r_rem;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_gnt_d   = w_sel;
          w_len_d   = w_len;
          w_state_d = StHeader;
        end
      end
      StHeader: begin
        if (io_bus.fifo_ready_in) begin
          w_rem_d   = r_len;
          w_state_d = StPayload;
        end
      end
      StPayload: begin
        if (io_bus.fifo_ready_in) begin
          w_rem_d = r_rem - 4'd1;
          if (r_rem == 4'd1) begin
            w_state_d  = StIdle;
            w_rr_ptr_d = (r_gnt == GW'(NUM_CH - 1)) ? '0 : r_gnt + 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_gnt4 = 4'(r_gnt);

  always_comb begin
    io_bus.fifo_data_valid_out = 1'b0;
    io_bus.fifo_data_out       = 8'h00;
    unique case (r_state)
      StHeader: begin
        io_bus.fifo_data_valid_out = 1'b1;
        io_bus.fifo_data_out       = {w_gnt4, r_len};
      end
      StPayload: begin
        io_bus.fifo_data_valid_out = 1'b1;
        io_bus.fifo_data_out       = r_mem[r_gnt][r_rptr[r_gnt]];
      end
      default: ;
    endcase
  end

  assign io_bus.ch_full_out     = r_full;
  assign io_bus.ch_overflow_out = r_ovf;

endmodule

// File: tb/tb_ft232h_tx_arbiter.sv
// Directed bench for ft232h_tx_arbiter: reset, single byte, round-robin, burst split,
// backpressure, overflow and mid-burst reset.
module tb_ft232h_tx_arbiter;
  localparam int unsigned NCH = 4;

  logic clk_in    = 1'b0;
  logic nreset_in = 1'b0;
  always #5 clk_in = ~clk_in;

  ft232h_tx_arbiter_if #(.NUM_CH(NCH)) bus ();

  ft232h_tx_arbiter #(
    .NUM_CH    (NCH),
    .FIFO_DEPTH(16),
    .MAX_BURST (15)
  ) dut (
    .clk_in   (clk_in),
    .nreset_in(nreset_in),
    .io_bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] got[$];

  // Record the byte that transfers at the coming edge, then advance one cycle.
  task automatic step();
    if (nreset_in && bus.fifo_data_valid_out && bus.fifo_ready_in) got.push_back(bus.fifo_data_out);
    @(posedge clk_in);
    #1;
  endtask

  task automatic push1(input int ch, input logic [7:0] d);
    bus.ch_data_in = '0;
    bus.ch_data_in[8*ch +: 8] = d;
    bus.ch_valid_in = '0;
    bus.ch_valid_in[ch] = 1'b1;
    step();
    bus.ch_valid_in = '0;
  endtask

  task automatic do_reset();
    nreset_in = 1'b0;
    bus.fifo_ready_in = 1'b0;
    bus.ch_valid_in = '0;
    bus.ch_data_in = '0;
    step();
    step();
    nreset_in = 1'b1;
    got.delete();
  endtask

  // Parks the arbiter on a stalled one-byte channel-3 packet so later pushes accumulate.
  task automatic park_on_ch3();
    bus.fifo_ready_in = 1'b0;
    push1(3, 8'hEE);
    step();
  endtask

  task automatic test_reset();
    nreset_in = 1'b0;
    bus.fifo_ready_in = 1'b1;
    bus.ch_valid_in = 4'b1111;
    step();
    step();
    n_checks++;
    if (bus.fifo_data_valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.fifo_data_valid_out);
    else n_pass++;
    n_checks++;
    if (bus.fifo_data_out !== 8'h00) $display("FAIL reset_data got %h want 00", bus.fifo_data_out);
    else n_pass++;
    n_checks++;
    if (bus.ch_full_out !== 4'b0000) $display("FAIL reset_full got %b want 0000", bus.ch_full_out);
    else n_pass++;
    n_checks++;
    if (bus.ch_overflow_out !== 4'b0000) $display("FAIL reset_ovf got %b want 0000", bus.ch_overflow_out);
    else n_pass++;
    bus.ch_valid_in = '0;
    nreset_in = 1'b1;
    step();
    n_checks++;
    if (bus.fifo_data_valid_out !== 1'b0) $display("FAIL reset_idle_valid got %b want 0", bus.fifo_data_valid_out);
    else n_pass++;
  endtask

  task automatic test_single_byte();
    logic [8:0] exp_t [4];
    exp_t = '{9'h000, 9'h121, 9'h1A5, 9'h000};
    do_reset();
    bus.fifo_ready_in = 1'b1;
    push1(2, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({bus.fifo_data_valid_out, bus.fifo_data_out} !== exp_t[i])
        $display("FAIL single_byte cycle %0d got %h want %h", i,
                 {bus.fifo_data_valid_out, bus.fifo_data_out}, exp_t[i]);
      else n_pass++;
      step();
    end
    n_checks++;
    if (got.size() != 2) $display("FAIL single_byte_count got %0d want 2", got.size());
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [8:0] exp_t [18];
    exp_t = '{9'h131, 9'h1EE, 9'h000, 9'h103, 9'h110, 9'h111, 9'h112, 9'h000, 9'h113,
              9'h120, 9'h121, 9'h122, 9'h000, 9'h133, 9'h130, 9'h131, 9'h132, 9'h000};
    do_reset();
    park_on_ch3();
    for (int i = 0; i < 3; i++) begin
      bus.ch_data_in = {8'h30 + 8'(i), 8'h00, 8'h20 + 8'(i), 8'h10 + 8'(i)};
      bus.ch_valid_in = 4'b1011;
      step();
    end
    bus.ch_valid_in = '0;
    bus.fifo_ready_in = 1'b1;
    for (int i = 0; i < 18; i++) begin
      n_checks++;
      if ({bus.fifo_data_valid_out, bus.fifo_data_out} !== exp_t[i])
        $display("FAIL round_robin cycle %0d got %h want %h", i,
                 {bus.fifo_data_valid_out, bus.fifo_data_out}, exp_t[i]);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_burst_split();
    logic [7:0] exp_q[$];
    int nb;
    do_reset();
    park_on_ch3();
    for (int i = 0; i < 16; i++) push1(0, 8'(i));
    bus.fifo_ready_in = 1'b1;
    nb = 16;
    for (int c = 0; c < 60; c++) begin
      if (nb < 20 && !bus.ch_full_out[0]) begin
        bus.ch_data_in = {24'h0, 8'(nb)};
        bus.ch_valid_in = 4'b0001;
        nb++;
      end else begin
        bus.ch_valid_in = '0;
      end
      step();
    end
    bus.ch_valid_in = '0;
    exp_q = '{8'h31, 8'hEE, 8'h0F};
    for (int i = 0; i < 15; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h05);
    for (int i = 15; i < 20; i++) exp_q.push_back(8'(i));
    n_checks++;
    if (got.size() != exp_q.size()) $display("FAIL burst_count got %0d want %0d", got.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) $display("FAIL burst_byte %0d got %h want %h", i, got[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (bus.ch_overflow_out !== 4'b0000) $display("FAIL burst_ovf got %b want 0000", bus.ch_overflow_out);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_q[$];
    logic       prev_v, prev_r, have_prev;
    logic [7:0] prev_d;
    do_reset();
    park_on_ch3();
    for (int i = 0; i < 15; i++) push1(0, 8'h40 + 8'(i));
    have_prev = 1'b0;
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_d = 8'h00;
    for (int c = 0; c < 300 && got.size() < 18; c++) begin
      if (have_prev && prev_v && !prev_r) begin
        n_checks++;
        if ({bus.fifo_data_valid_out, bus.fifo_data_out} !== {1'b1, prev_d})
          $display("FAIL stall_hold cycle %0d got %h want %h", c,
                   {bus.fifo_data_valid_out, bus.fifo_data_out}, {1'b1, prev_d});
        else n_pass++;
      end
      bus.fifo_ready_in = 1'($urandom_range(0, 1));
      prev_v = bus.fifo_data_valid_out;
      prev_d = bus.fifo_data_out;
      prev_r = bus.fifo_ready_in;
      have_prev = 1'b1;
      step();
    end
    exp_q = '{8'h31, 8'hEE, 8'h0F};
    for (int i = 0; i < 15; i++) exp_q.push_back(8'h40 + 8'(i));
    n_checks++;
    if (got.size() != 18) $display("FAIL bp_count got %0d want 18", got.size());
    else n_pass++;
    for (int i = 0; i < 18 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) $display("FAIL bp_byte %0d got %h want %h", i, got[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_overflow_reset();
    logic [7:0] exp_q[$];
    do_reset();
    for (int i = 0; i < 17; i++) push1(1, 8'h60 + 8'(i));
    step();
    n_checks++;
    if (bus.ch_full_out !== 4'b0010) $display("FAIL ovf_full got %b want 0010", bus.ch_full_out);
    else n_pass++;
    n_checks++;
    if (bus.ch_overflow_out !== 4'b0010) $display("FAIL ovf_flag got %b want 0010", bus.ch_overflow_out);
    else n_pass++;
    bus.fifo_ready_in = 1'b1;
    for (int c = 0; c < 40; c++) step();
    exp_q = '{8'h11, 8'h60, 8'h1F};
    for (int i = 1; i < 16; i++) exp_q.push_back(8'h60 + 8'(i));
    n_checks++;
    if (got.size() != 18) $display("FAIL ovf_count got %0d want 18", got.size());
    else n_pass++;
    for (int i = 0; i < 18 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) $display("FAIL ovf_byte %0d got %h want %h", i, got[i], exp_q[i]);
      else n_pass++;
    end
    bus.fifo_ready_in = 1'b0;
    for (int i = 0; i < 8; i++) push1(2, 8'h80 + 8'(i));
    bus.fifo_ready_in = 1'b1;
    for (int c = 0; c < 40 && got.size() < 23; c++) step();
    exp_q = '{8'h21, 8'h80, 8'h27, 8'h81, 8'h82};
    n_checks++;
    if (got.size() != 23) $display("FAIL midreset_pre_count got %0d want 23", got.size());
    else n_pass++;
    for (int i = 0; i < 5 && (18 + i) < got.size(); i++) begin
      n_checks++;
      if (got[18+i] !== exp_q[i]) $display("FAIL midreset_byte %0d got %h want %h", i, got[18+i], exp_q[i]);
      else n_pass++;
    end
    nreset_in = 1'b0;
    step();
    n_checks++;
    if ({bus.fifo_data_valid_out, bus.fifo_data_out} !== 9'h000)
      $display("FAIL midreset_out got %h want 000", {bus.fifo_data_valid_out, bus.fifo_data_out});
    else n_pass++;
    n_checks++;
    if ({bus.ch_full_out, bus.ch_overflow_out} !== 8'h00)
      $display("FAIL midreset_flags got %h want 00", {bus.ch_full_out, bus.ch_overflow_out});
    else n_pass++;
    nreset_in = 1'b1;
    for (int c = 0; c < 20; c++) step();
    n_checks++;
    if (got.size() != 23) $display("FAIL midreset_post_count got %0d want 23", got.size());
    else n_pass++;
    n_checks++;
    if (bus.fifo_data_valid_out !== 1'b0) $display("FAIL midreset_post_valid got %b want 0", bus.fifo_data_valid_out);
    else n_pass++;
  endtask

  initial begin
    bus.ch_data_in    = '0;
    bus.ch_valid_in   = '0;
    bus.fifo_ready_in = 1'b0;
    #1;
    test_reset();
    test_single_byte();
    test_round_robin();
    test_burst_split();
    test_backpressure();
    test_overflow_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/ft232h_tx_arbiter.md
# ft232h_tx_arbiter

Round-robin arbiter and packetizer that shares the single FT232H async-FIFO transmit path between `NUM_CH` independent byte producers. Each producer writes into a private input FIFO; the arbiter grants one channel at a time and emits a one-byte header followed by a burst of that channel's bytes. The arbiter's output feeds `fifo_data_in` / `fifo_data_valid_in` of `ft232h_async_driver`, which stalls it through `fifo_ready_in`. The host demultiplexes the stream by header.

## Interface
- `NUM_CH`, 4: number of requesting channels, 1..16.
- `FIFO_DEPTH`, 16: per-channel FIFO depth in bytes; a power of 2, 2..256.
- `MAX_BURST`, 15: maximum payload bytes per packet, 1..15.

- `clk_in`  in  1  single clock; all logic is on its rising edge.
- `nreset_in`  in  1  synchronous, active-low reset.
- `ch_data_in`  in  8*NUM_CH  channel k's byte is at bits [8k+7:8k].
- `ch_valid_in`  in  NUM_CH  push strobe for each channel.
- `ch_full_out`  out  NUM_CH  the channel's FIFO holds FIFO_DEPTH bytes.
- `ch_overflow_out`  out  NUM_CH  sticky flag: a push was dropped because the FIFO was full.
- `fifo_data_out`  out  8  header or payload byte to the driver.
- `fifo_data_valid_out`  out  1  `fifo_data_out` is valid.
- `fifo_ready_in`  in  1  the driver can accept a byte this cycle.

## Operation
- **Channel FIFO push**
  - A push occurs when `ch_valid_in[k]` is high and the FIFO is not full.
  - A push while full is dropped and sets `ch_overflow_out[k]`. Only reset clears it.
  - A push and a pop on the same channel in the same cycle both take effect; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - The count is $clog2(FIFO_DEPTH)+1 bits wide.
- **Output transfer:** a byte transfers on a cycle where `fifo_data_valid_out` and `fifo_ready_in` are both high. While valid is high and ready is low, `fifo_data_out` holds stable.
- **State machine:** IDLE, HEADER, PAYLOAD.
  - **IDLE**
    - Scans channels starting at `rr_ptr` and wrapping, and selects the first channel with count > 0 as `gnt`.
    - Latches `len = min(count[gnt], MAX_BURST)` and goes to HEADER on the next edge.
    - If no channel has data, stays in IDLE.
  - **HEADER**
    - `fifo_data_out = {gnt[3:0], len[3:0]}`.
    - Goes to PAYLOAD when the header is accepted; `remaining = len`.
  - **PAYLOAD**
    - `fifo_data_out` is the head byte of FIFO `gnt`.
    - Each accept pops that FIFO and decrements `remaining`.
    - The accept with `remaining == 1` goes to IDLE and sets `rr_ptr = (gnt+1) mod NUM_CH`.
- **Burst length:** bytes pushed into the granted channel during its burst do not extend `len`; they are served in a later packet.
- **Outputs by state:** `fifo_data_valid_out` is high exactly in HEADER and PAYLOAD. In IDLE, `fifo_data_out = 8'h00`.

## Timing
- **Reset values (`nreset_in` low at an edge):**
  - `fifo_data_valid_out` = 0 and `fifo_data_out` = 0.
  - `ch_full_out` = 0 and `ch_overflow_out` = 0.
  - All FIFOs are emptied, `rr_ptr` = 0, state = IDLE.
  - Reset mid-packet truncates the packet; no further bytes of it are emitted.
- **Latency:** with the arbiter idle and everything empty, a push at edge t makes the count visible after t. IDLE grants at edge t+1. Header valid is high after t+1.
- **Back-to-back throughput:** with `fifo_ready_in` held high, a packet of `len` bytes occupies `len+1` consecutive valid cycles. This is followed by exactly one IDLE cycle before the next header.
- **Fairness:** a channel with pending data waits at most NUM_CH−1 packets before it is granted.
- **Full flag:** `ch_full_out[k]` is registered from the count and updates the cycle after the push or pop.

## Test plan
- **Single byte:** reset, then push 8'hA5 on channel 2.
  - Expect the header 8'h21 and then 8'hA5, each accepted once.
  - Valid is low afterwards.
- **Round-robin:** fill channels 0, 1 and 3 with 3 bytes each simultaneously, with ready held high.
  - Expect headers 8'h03, 8'h13, 8'h33 in that order.
  - Payloads arrive in push order, with one idle cycle between packets.
- **Burst split:** push 20 bytes (0..19) to channel 0 with ready high.
  - Expect header 8'h0F and bytes 0..14, then header 8'h05 and bytes 15..19.
- **Backpressure:** toggle `fifo_ready_in` randomly during a 15-byte burst.
  - `fifo_data_out` must be stable whenever valid is high and ready is low.
  - The byte sequence must be unchanged.
- **Overflow and reset:**
  - Push FIFO_DEPTH+1 bytes to channel 1 while ready is low. Expect `ch_full_out[1]` and `ch_overflow_out[1]` set, and the last byte absent from the output.
  - Assert `nreset_in` mid-burst. Expect all outputs to be 0 on the next cycle and no further bytes from that packet.
